mdu_operand_stage: RTL
======================

Name: mdu_operand_stage

Overview:
- Registered front-end of the multiply/divide unit. Conditions both operands to PAR+1 bits (sign- or zero-extension, optional magnitude for signed division) and precomputes the division corner-case flags.
- Decouples the issue side from the MDU core with a valid/ready handshake and a 2-entry skid buffer.
- Sits between operand fetch and the iterative multiply/divide datapath.
- Naming: operand0 = multiplicand/divisor (rs2); operand1 = multiplier/dividend (rs1).

Parameters:
- PAR, 32, operand width in bits.
- OPCODE_WIDTH, 3, opcode width. Encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ABS_DIV, 1, 1 = for signed division, emit magnitudes plus sign flags; 0 = emit sign-extended values only.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill; empties the buffer.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_opcode  in  OPCODE_WIDTH  operation.
- in_op0  in  PAR  multiplicand/divisor.
- in_op1  in  PAR  multiplier/dividend.
- out_valid  out  1  conditioned beat valid.
- out_ready  in  1  core accepts the beat.
- out_opcode  out  OPCODE_WIDTH  opcode passed through.
- out_op0  out  PAR+1  conditioned operand0.
- out_op1  out  PAR+1  conditioned operand1.
- out_div_zero  out  1  division with divisor == 0.
- out_div_ovf  out  1  signed division of most-negative value by -1.
- out_neg_q  out  1  quotient must be negated after an unsigned-magnitude divide.
- out_neg_r  out  1  remainder must be negated.

Behaviour:
- Reset (rst_n low, asynchronous): both buffer entries are empty; out_valid=0; in_ready=1; every data and flag output is 0.
- Conditioning rules:
  - Division (opcode[2]=1): unsigned if opcode[0]=1, else signed. Both operands follow the same rule.
  - Multiplication: op0 is unsigned for 010 and 011. op1 is unsigned for 011 only.
  - Unsigned operand: {1'b0, x}. Signed operand: {x[PAR-1], x}.
- ABS_DIV=1, signed division: each operand is emitted as {1'b0, |x|}. |MIN| = 2^(PAR-1) must come out without overflow.
- Flag definitions:
  - div_zero = div & (op0 == 0).
  - div_ovf = div & signed & (op1 == MIN) & (op0 == all-ones).
  - neg_q = ABS_DIV & div & signed & (s0 ^ s1) & !div_zero & !div_ovf.
  - neg_r = ABS_DIV & div & signed & s1 & !div_zero & !div_ovf.
  - Every flag is 0 for multiplication and when ABS_DIV=0.
- Latency: an accepted beat appears on the outputs on the next cycle. Conditioning is computed before the register.
- Handshake:
  - A beat is accepted when in_valid & in_ready; it is consumed when out_valid & out_ready.
  - Outputs hold stable while out_valid & !out_ready.
  - in_ready is a register output: 1 whenever the skid entry is empty.
- Buffer states:
  - EMPTY: accept loads main; go to ONE.
  - ONE: consume without accept -> EMPTY. Consume with accept -> main reloads, stay ONE. Accept without consume -> beat goes to skid, go to TWO; in_ready drops next cycle.
  - TWO: in_ready=0. Consume moves skid to main -> ONE.
- Throughput: one beat per cycle sustained when out_ready=1. No bubble on simultaneous accept and consume.
- flush: has priority over accept and consume in the same cycle. Result is EMPTY next cycle with out_valid=0 and in_ready=1; the incoming beat is dropped.
- Reset asserted mid-operation: returns to EMPTY immediately, without waiting for a clock edge.
- The stage holds no state beyond the two entries. Order is preserved.

Decomposition:
- Package mdu_pkg:
  - opcode enum and localparams OP_DIV_BIT=2, OP_DIVU_BIT=0, OP_MULU0_BIT=1.
  - a packed struct cond_beat_t: opcode, op0, op1, div_zero, div_ovf, neg_q, neg_r.
- One sub-module: mdu_operand_cond. Purely combinational; maps opcode and raw operands to a cond_beat_t, and is instantiated once before the buffer.
- The buffer/FSM lives in mdu_operand_stage.

Test Plan (PAR=32):
- Reset, then MULHSU with op0=0xFFFFFFFF, op1=0xFFFFFFFF -> next cycle out_op0=0x0FFFFFFFF, out_op1=0x1FFFFFFFF, all flags 0.
- DIV with op1=0x80000000, op0=0x00000003, ABS_DIV=1 -> out_op1=0x080000000, out_op0=0x000000003, neg_q=1, neg_r=1.
- DIV with op1=0x80000000, op0=0xFFFFFFFF -> div_ovf=1, neg_q=0. REMU with op0=0 -> div_zero=1, out_op0=0.
- Backpressure: out_ready=0, three back-to-back beats A, B, C -> A held on outputs, B in skid, in_ready=0 on cycle 3 and C not accepted. Raise out_ready -> A, B, C delivered in order with no loss or duplication.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles -> 10 beats out on consecutive cycles; in_ready stays 1 throughout.
- flush while in TWO state alongside an incoming beat -> next cycle out_valid=0, in_ready=1, no beat emitted. Assert rst_n low mid-stall -> outputs are 0 before the next edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the MDU operand stage
package mdu_pkg;

    localparam int MDU_PAR = 32;
    localparam int MDU_OPW = 3;

    localparam int OP_DIV_BIT   = 2;
    localparam int OP_DIVU_BIT  = 0;
    localparam int OP_MULU0_BIT = 1;

    typedef enum logic [MDU_OPW-1:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_opcode_e;

    typedef struct packed {
        logic [MDU_OPW-1:0] opcode;
        logic [MDU_PAR:0]   op0;
        logic [MDU_PAR:0]   op1;
        logic               div_zero;
        logic               div_ovf;
        logic               neg_q;
        logic               neg_r;
    } cond_beat_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/mdu_operand_stage_if.sv
// rtl/mdu_operand_stage_if.sv - issue-side and core-side handshake bundle of the operand stage
interface mdu_operand_stage_if #(
    parameter int PAR          = 32,
    parameter int OPCODE_WIDTH = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [OPCODE_WIDTH-1:0] in_opcode;
    logic [PAR-1:0]          in_op0;
    logic [PAR-1:0]          in_op1;

    logic                    out_valid;
    logic                    out_ready;
    logic [OPCODE_WIDTH-1:0] out_opcode;
    logic [PAR:0]            out_op0;
    logic [PAR:0]            out_op1;
    logic                    out_div_zero;
    logic                    out_div_ovf;
    logic                    out_neg_q;
    logic                    out_neg_r;

    // master is the issue side that also consumes the conditioned beat
    modport master (
        output in_valid, in_opcode, in_op0, in_op1, out_ready,
        input  in_ready, out_valid, out_opcode, out_op0, out_op1,
        input  out_div_zero, out_div_ovf, out_neg_q, out_neg_r
    );

    modport slave (
        input  in_valid, in_opcode, in_op0, in_op1, out_ready,
        output in_ready, out_valid, out_opcode, out_op0, out_op1,
        output out_div_zero, out_div_ovf, out_neg_q, out_neg_r
    );
endinterface

// File: rtl/mdu_operand_cond.sv
// rtl/mdu_operand_cond.sv - combinational operand extension/magnitude and division corner flags
module mdu_operand_cond
    import mdu_pkg::*;
#(
    parameter int PAR          = MDU_PAR,
    parameter int OPCODE_WIDTH = MDU_OPW,
    parameter int ABS_DIV      = 1
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [PAR-1:0]          op0,
    input  logic [PAR-1:0]          op1,
    output cond_beat_t              beat
);

    localparam logic USE_ABS = (ABS_DIV != 0);
    localparam logic [PAR-1:0] MIN_VAL = {1'b1, {(PAR-1){1'b0}}};

    logic           is_div;
    logic           signed_div;
    logic           op0_uns;
    logic           op1_uns;
    logic           s0;
    logic           s1;
    logic [PAR-1:0] mag0;
    logic [PAR-1:0] mag1;
    logic           div_zero;
    logic           div_ovf;

    always_comb begin
        is_div     = opcode[OP_DIV_BIT];
        signed_div = is_div & ~opcode[OP_DIVU_BIT];
        // MULHSU/MULHU treat op0 as unsigned; only MULHU treats op1 as unsigned
        op0_uns    = is_div ? opcode[OP_DIVU_BIT] : opcode[OP_MULU0_BIT];
        op1_uns    = is_div ? opcode[OP_DIVU_BIT]
                            : (opcode[OP_MULU0_BIT] & opcode[OP_DIVU_BIT]);
        s0         = ~op0_uns & op0[PAR-1];
        s1         = ~op1_uns & op1[PAR-1];

        // two's-complement negate of MIN yields MIN, which is the correct magnitude once zero-extended
        mag0       = s0 ? (~op0 + 1'b1) : op0;
        mag1       = s1 ? (~op1 + 1'b1) : op1;

        div_zero   = is_div & (op0 == '0);
        div_ovf    = signed_div & (op1 == MIN_VAL) & (&op0);

        beat          = '0;
        beat.opcode   = opcode;
        if (USE_ABS && signed_div) begin
            beat.op0 = {1'b0, mag0};
            beat.op1 = {1'b0, mag1};
        end else begin
            beat.op0 = {s0, op0};
            beat.op1 = {s1, op1};
        end
        beat.div_zero = USE_ABS & div_zero;
        beat.div_ovf  = USE_ABS & div_ovf;
        beat.neg_q    = USE_ABS & signed_div & (s0 ^ s1) & ~div_zero & ~div_ovf;
        beat.neg_r    = USE_ABS & signed_div & s1 & ~div_zero & ~div_ovf;
    end

endmodule

// File: rtl/mdu_operand_stage.sv
// rtl/mdu_operand_stage.sv - registered MDU operand front-end with a 2-entry skid buffer
module mdu_operand_stage
    import mdu_pkg::*;
#(
    parameter int PAR          = MDU_PAR,
    parameter int OPCODE_WIDTH = MDU_OPW,
    parameter int ABS_DIV      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    mdu_operand_stage_if.slave bus
);

    cond_beat_t cond_beat;
    cond_beat_t main_d;
    cond_beat_t main_q;
    cond_beat_t skid_d;
    cond_beat_t skid_q;
    buf_state_e state_d;
    buf_state_e state_q;
    logic       in_ready_d;
    logic       in_ready_q;
    logic       accept;
    logic       consume;

    mdu_operand_cond #(
        .PAR          (PAR),
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .ABS_DIV      (ABS_DIV)
    ) u_cond (
        .opcode (bus.in_opcode),
        .op0    (bus.in_op0),
        .op1    (bus.in_op1),
        .beat   (cond_beat)
    );

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        state_d    = state_q;
        accept     = bus.in_valid & in_ready_q;
        consume    = (state_q != BUF_EMPTY) & bus.out_ready;

        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    main_d  = cond_beat;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && consume) begin
                    main_d = cond_beat;
                end else if (consume) begin
                    state_d = BUF_EMPTY;
                end else if (accept) begin
                    skid_d  = cond_beat;
                    state_d = BUF_TWO;
                end
            end
            BUF_TWO: begin
                // in_ready is low here, so only the drain path exists
                if (consume) begin
                    main_d  = skid_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase

        if (flush) begin
            state_d = BUF_EMPTY;
        end

        in_ready_d = (state_d != BUF_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = (state_q != BUF_EMPTY);
    assign bus.out_opcode   = main_q.opcode;
    assign bus.out_op0      = main_q.op0;
    assign bus.out_op1      = main_q.op1;
    assign bus.out_div_zero = main_q.div_zero;
    assign bus.out_div_ovf  = main_q.div_ovf;
    assign bus.out_neg_q    = main_q.neg_q;
    assign bus.out_neg_r    = main_q.neg_r;

endmodule
